imem_cache_ctrl_p: RTL and testbench
====================================

Name: imem_cache_ctrl_p

Overview:
Parametrised instruction/data-port memory controller: direct-mapped, write-back, write-allocate cache with multi-word lines, in front of a handshaked word-wide backing memory. Successor to the single-word memory controller. Adds configurable geometry, burst line refill and writeback, an explicit miss FSM and a req/ack memory interface. Sits between the core fetch/LSU port (memReady stall protocol) and the backing memory.

Parameters:
DATA_W, 32, data word width in bits (multiple of 8)
ADDR_W, 32, byte address width
LINE_WORDS, 4, words per cache line (power of 2, >=2)
SETS, 64, number of lines (power of 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
address  in  ADDR_W  byte address; low log2(DATA_W/8) bits ignored
datain  in  DATA_W  write data
wen  in  1  write request
ren  in  1  read request
byte_select_vector  in  DATA_W/8  byte enables for writes
memReady  out  1  high = request complete this cycle / no stall
dataout  out  DATA_W  read data, valid when ren && memReady
mem_addr  out  ADDR_W  word address to backing memory
mem_wdata  out  DATA_W  writeback data
mem_wen  out  1  writeback word request
mem_ren  out  1  refill word request
mem_rdata  in  DATA_W  refill data, valid with mem_ack
mem_ack  in  1  one-cycle acknowledge per word

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Address split: word offset log2(LINE_WORDS), index log2(SETS), remainder is tag. Per line: valid, dirty, tag, LINE_WORDS data words.
- Reset (sampled at posedge clk): all valid/dirty bits cleared, FSM to IDLE, word counter 0, mem_ren=mem_wen=0, mem_addr=0, mem_wdata=0, dataout=0. memReady=1 while reset is high. A reset during WRITEBACK/REFILL aborts the burst. The partial line is discarded and left invalid.
- FSM states: IDLE, WRITEBACK, REFILL, RESPOND.
- IDLE, no request: memReady=1.
- IDLE, read hit: memReady=1 combinationally; dataout = cached word in the same cycle (zero wait).
- IDLE, write hit: memReady=1; the selected bytes are written at posedge and dirty is set.
- IDLE, miss (valid=0 or tag mismatch) on ren or wen: memReady=0.
  - Victim valid and dirty: go to WRITEBACK.
  - Otherwise: go to REFILL.
  - The request address is latched. Core must hold address/wen/ren/datain stable until memReady=1.
- WRITEBACK: mem_wen=1, mem_addr = {victim tag, index, counter}, mem_wdata = victim word[counter]. Each mem_ack increments counter. After the LINE_WORDS-th ack: clear counter, clear dirty, go to REFILL.
- REFILL: mem_ren=1, mem_addr = {req tag, index, counter}, words fetched 0..LINE_WORDS-1 in order. Each mem_ack writes mem_rdata into line[counter]. After the last ack: valid=1, tag updated, go to RESPOND.
- RESPOND: behaves as a hit on the latched request.
  - Read: memReady=1, dataout = word.
  - Write: byte-masked write, dirty=1, memReady=1.
  - Returns to IDLE next cycle.
- mem_ren/mem_wen stay high across words. No ack means wait indefinitely. Never both high.
- wen && ren together: treated as a write; dataout holds its previous value.
- No request in IDLE: no state change; dataout holds.
- Miss penalty without writeback: LINE_WORDS acks + 1 cycle (RESPOND). Dirty victim adds LINE_WORDS acks.

Optional Feature:
IMEM_CRITICAL_FWD_EN.
- Defined: during REFILL for a read, when the ack for the requested word offset arrives:
  - dataout = mem_rdata and memReady=1 for that cycle.
  - The refill continues in the background. The FSM still ends in IDLE without a RESPOND cycle.
  - Any new request during the remaining refill stalls (memReady=0) until the line is valid.
  - Writes are unaffected and still use RESPOND.
- Undefined: no forwarding; memReady only in RESPOND.

Test Plan:
- Reset, then ren at 0x100 with mem_ack one cycle after each request:
  - mem_ren words 0x40..0x43.
  - memReady low for 4 acks + 1 cycle; dataout = word 0.
  - Repeat read → memReady=1 same cycle.
- Write 0xDEADBEEF byte_select 4'b0011 to a cached 0x104 holding 0x11223344 → read returns 0x1122BEEF; no memory traffic.
- Dirty line at index 0, then read the same index with a different tag (e.g. 0x1000 with SETS=64, LINE_WORDS=4) → 4 mem_wen writes of the old line, then 4 mem_ren reads, then memReady.
- Assert reset mid-REFILL after 2 acks → mem_ren=0 next cycle; re-read of the same address performs a full 4-word refill.
- Hold mem_ack low 10 cycles during refill → memReady stays 0, mem_addr stable, no corruption.
- With IMEM_CRITICAL_FWD_EN, read offset 2 on a miss → memReady=1 on the 3rd ack with dataout=mem_rdata; the following request stalls until the 4th ack.

Source files
------------

// File: rtl/imem_cache_ctrl_p_if.sv
// Core-side (memReady stall protocol) and backing-memory (req/ack) bus of imem_cache_ctrl_p.
// The controller uses the slave modport; the core/memory side uses master.
interface imem_cache_ctrl_p_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   datain;
  logic                wen;
  logic                ren;
  logic [DATA_W/8-1:0] byte_select_vector;
  logic                memReady;
  logic [DATA_W-1:0]   dataout;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_wen;
  logic                mem_ren;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ack;

  modport slave (
    input  address, datain, wen, ren, byte_select_vector, mem_rdata, mem_ack,
    output memReady, dataout, mem_addr, mem_wdata, mem_wen, mem_ren
  );

  modport master (
    output address, datain, wen, ren, byte_select_vector, mem_rdata, mem_ack,
    input  memReady, dataout, mem_addr, mem_wdata, mem_wen, mem_ren
  );
endinterface

// File: rtl/imem_cache_ctrl_p.sv
// Direct-mapped write-back/write-allocate cache controller with burst refill and writeback.
// Optional macro IMEM_CRITICAL_FWD_EN forwards the requested word straight from a read refill.
module imem_cache_ctrl_p #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64
) (
  input logic             clk,
  input logic             reset,
  imem_cache_ctrl_p_if.slave bus
);
  localparam int BYTES   = DATA_W / 8;
  localparam int BYTE_W  = $clog2(BYTES);
  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - BYTE_W - OFF_W - IDX_W;
  localparam int WADDR_W = TAG_W + IDX_W + OFF_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_e;

  state_e              state_q;
  logic [OFF_W-1:0]    cnt_q;
  logic [SETS-1:0]     valid_q;
  logic [SETS-1:0]     dirty_q;
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [DATA_W-1:0]   data_q [SETS*LINE_WORDS];
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_wdata_q;
  logic [BYTES-1:0]    req_be_q;
  logic                req_wr_q;
  logic                mem_ren_q;
  logic                mem_wen_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   dataout_q;

  logic [ADDR_W-1:0]   cur_addr;
  logic [OFF_W-1:0]    cur_off;
  logic [IDX_W-1:0]    cur_idx;
  logic [TAG_W-1:0]    cur_tag;
  logic [DATA_W-1:0]   cur_wdata;
  logic [BYTES-1:0]    cur_be;
  logic [DATA_W-1:0]   cur_word;
  logic                hit;
  logic                req_active;
  logic [OFF_W-1:0]    cnt_d;
  logic                last_ack;
  logic                store_en;
  logic                fwd_now;
  logic                fwd_seen;
  logic                ready_d;
  logic [DATA_W-1:0]   dataout_d;
  logic                unused_addr_bits;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [TAG_W-1:0] t,
                                                  input logic [IDX_W-1:0] i,
                                                  input logic [OFF_W-1:0] o);
    word_addr = '0;
    word_addr[WADDR_W-1:0] = {t, i, o};
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [BYTES-1:0]  be);
    merge_bytes = old_w;
    for (int b = 0; b < BYTES; b++) begin
      if (be[b]) merge_bytes[8*b +: 8] = new_w[8*b +: 8];
    end
  endfunction

  // Outside IDLE every lookup refers to the latched miss request.
  assign cur_addr   = (state_q == IDLE) ? bus.address : req_addr_q;
  assign cur_wdata  = (state_q == IDLE) ? bus.datain : req_wdata_q;
  assign cur_be     = (state_q == IDLE) ? bus.byte_select_vector : req_be_q;
  assign cur_off    = cur_addr[BYTE_W +: OFF_W];
  assign cur_idx    = cur_addr[BYTE_W+OFF_W +: IDX_W];
  assign cur_tag    = cur_addr[ADDR_W-1 -: TAG_W];
  assign cur_word   = data_q[{cur_idx, cur_off}];
  assign hit        = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign req_active = bus.ren | bus.wen;
  assign cnt_d      = cnt_q + OFF_W'(1);
  assign last_ack   = bus.mem_ack && (cnt_q == OFF_W'(LINE_WORDS - 1));
  assign store_en   = !reset && (((state_q == IDLE) && bus.wen && hit) ||
                                 ((state_q == RESPOND) && req_wr_q));
  assign unused_addr_bits = ^cur_addr;

`ifdef IMEM_CRITICAL_FWD_EN
  logic fwd_done_q;
  assign fwd_now  = (state_q == REFILL) && !req_wr_q && bus.mem_ack && (cnt_q == cur_off);
  assign fwd_seen = fwd_now | fwd_done_q;
`else
  assign fwd_now  = 1'b0;
  assign fwd_seen = 1'b0;
`endif

  always_comb begin
    ready_d   = 1'b0;
    dataout_d = dataout_q;
    if (reset) begin
      ready_d   = 1'b1;
      dataout_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!req_active) begin
            ready_d = 1'b1;
          end else if (hit) begin
            ready_d = 1'b1;
            if (!bus.wen) dataout_d = cur_word;
          end
        end
        RESPOND: begin
          ready_d = 1'b1;
          if (!req_wr_q) dataout_d = cur_word;
        end
        REFILL: begin
          if (fwd_now) begin
            ready_d   = 1'b1;
            dataout_d = bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; validity is tracked by valid_q alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (store_en) begin
        data_q[{cur_idx, cur_off}] <= merge_bytes(cur_word, cur_wdata, cur_be);
      end else if ((state_q == REFILL) && bus.mem_ack) begin
        data_q[{cur_idx, cnt_q}] <= bus.mem_rdata;
      end
      if ((state_q == REFILL) && last_ack) tag_q[cur_idx] <= cur_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      req_wr_q    <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dataout_q   <= '0;
`ifdef IMEM_CRITICAL_FWD_EN
      fwd_done_q  <= 1'b0;
`endif
    end else begin
      dataout_q <= dataout_d;
      case (state_q)
        IDLE: begin
          if (req_active && hit) begin
            if (bus.wen) dirty_q[cur_idx] <= 1'b1;
          end else if (req_active) begin
            req_addr_q  <= bus.address;
            req_wdata_q <= bus.datain;
            req_be_q    <= bus.byte_select_vector;
            req_wr_q    <= bus.wen;
            cnt_q       <= '0;
            // The line is being replaced, so it stops hitting until the refill completes.
            valid_q[cur_idx] <= 1'b0;
`ifdef IMEM_CRITICAL_FWD_EN
            fwd_done_q  <= 1'b0;
`endif
            if (valid_q[cur_idx] && dirty_q[cur_idx]) begin
              state_q     <= WRITEBACK;
              mem_wen_q   <= 1'b1;
              mem_addr_q  <= word_addr(tag_q[cur_idx], cur_idx, '0);
              mem_wdata_q <= data_q[{cur_idx, {OFF_W{1'b0}}}];
            end else begin
              state_q    <= REFILL;
              mem_ren_q  <= 1'b1;
              mem_addr_q <= word_addr(cur_tag, cur_idx, '0);
            end
          end
        end
        WRITEBACK: begin
          if (last_ack) begin
            cnt_q            <= '0;
            dirty_q[cur_idx] <= 1'b0;
            state_q          <= REFILL;
            mem_wen_q        <= 1'b0;
            mem_ren_q        <= 1'b1;
            mem_addr_q       <= word_addr(cur_tag, cur_idx, '0);
          end else if (bus.mem_ack) begin
            cnt_q       <= cnt_d;
            mem_addr_q  <= word_addr(tag_q[cur_idx], cur_idx, cnt_d);
            mem_wdata_q <= data_q[{cur_idx, cnt_d}];
          end
        end
        REFILL: begin
`ifdef IMEM_CRITICAL_FWD_EN
          if (fwd_now) fwd_done_q <= 1'b1;
`endif
          if (last_ack) begin
            cnt_q            <= '0;
            mem_ren_q        <= 1'b0;
            valid_q[cur_idx] <= 1'b1;
            state_q          <= fwd_seen ? IDLE : RESPOND;
          end else if (bus.mem_ack) begin
            cnt_q      <= cnt_d;
            mem_addr_q <= word_addr(cur_tag, cur_idx, cnt_d);
          end
        end
        RESPOND: begin
          if (req_wr_q) dirty_q[cur_idx] <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.memReady  = ready_d;
  assign bus.dataout   = dataout_d;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_ren   = mem_ren_q;
endmodule

// File: tb/tb_imem_cache_ctrl_p.sv
// Directed bench for imem_cache_ctrl_p with a word-addressed backing memory model.
// Expectations follow IMEM_CRITICAL_FWD_EN when the build defines it.
module tb_imem_cache_ctrl_p;
  localparam int DATA_W = 32, ADDR_W = 32, LINE_WORDS = 4, SETS = 64;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          expStall;
    logic        chkData;
    logic [31:0] expData;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addrR = '0;
  logic [31:0] wdataR = '0;
  logic        renR = 1'b0;
  logic        wenR = 1'b0;
  logic [3:0]  beR = '0;
  logic        memAck = 1'b0;
  logic [31:0] memRdata = '0;
  logic        holdAck = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] bmem [logic [31:0]];
  logic [31:0] rdLog[$];
  logic [31:0] wrAddrLog[$];
  logic [31:0] wrDataLog[$];

  imem_cache_ctrl_p_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  assign bus.address            = addrR;
  assign bus.datain             = wdataR;
  assign bus.ren                = renR;
  assign bus.wen                = wenR;
  assign bus.byte_select_vector = beR;
  assign bus.mem_ack            = memAck;
  assign bus.mem_rdata          = memRdata;

  imem_cache_ctrl_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memInit(input logic [31:0] a);
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  // Backing memory: acks every other cycle while a request is up, unless holdAck is set.
  always @(negedge clk) begin
    if (memAck) begin
      memAck = 1'b0;
    end else if ((bus.mem_ren || bus.mem_wen) && !holdAck) begin
      memAck = 1'b1;
      if (bus.mem_ren) begin
        memRdata = bmem.exists(bus.mem_addr) ? bmem[bus.mem_addr] : memInit(bus.mem_addr);
        rdLog.push_back(bus.mem_addr);
      end else begin
        bmem[bus.mem_addr] = bus.mem_wdata;
        wrAddrLog.push_back(bus.mem_addr);
        wrDataLog.push_back(bus.mem_wdata);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic r, input logic w,
                               input logic [31:0] d, input logic [3:0] be);
    addrR  = a;
    renR   = r;
    wenR   = w;
    wdataR = d;
    beR    = be;
  endtask

  task automatic waitReady(input string name, output int stall, output logic [31:0] data);
    logic done;
    done  = 1'b0;
    stall = 0;
    data  = '0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      #1;
      if (bus.memReady === 1'b1) begin
        data = bus.dataout;
        done = 1'b1;
      end else begin
        stall++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: memReady never rose, expected within 400 cycles", name);
    end
  endtask

  task automatic doTransaction(input string name, input logic [31:0] a, input logic r,
                               input logic w, input logic [31:0] d, input logic [3:0] be,
                               input int expStall, input logic chk, input logic [31:0] expData);
    int          stall;
    logic [31:0] data;
    applyStimulus(a, r, w, d, be);
    waitReady(name, stall, data);
    @(posedge clk);
    #1;
    applyStimulus(a, 1'b0, 1'b0, '0, '0);
    checkOutput({name, " stall"}, 64'(stall), 64'(expStall));
    if (chk) checkOutput({name, " data"}, 64'(data), 64'(expData));
  endtask

  initial begin
    vec_t vecs[9];
    int   base;
    int   n;
    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        4'h0, 8, 1'b1, 32'hC0DE0040};
    vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,        4'h0, 0, 1'b1, 32'hC0DE0040};
    vecs[2] = '{1'b1, 1'b0, 32'h10C, 32'h0,        4'h0, 0, 1'b1, 32'hC0DE0043};
    vecs[3] = '{1'b0, 1'b1, 32'h104, 32'h11223344, 4'hF, 0, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 4'h3, 0, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h104, 32'h0,        4'h0, 0, 1'b1, 32'h1122BEEF};
    vecs[6] = '{1'b1, 1'b1, 32'h108, 32'h55667788, 4'hF, 0, 1'b1, 32'h1122BEEF};
    vecs[7] = '{1'b1, 1'b0, 32'h108, 32'h0,        4'h0, 0, 1'b1, 32'h55667788};
    vecs[8] = '{1'b1, 1'b0, 32'h107, 32'h0,        4'h0, 0, 1'b1, 32'h1122BEEF};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset memReady", 64'(bus.memReady), 64'(1));
    checkOutput("reset mem_ren", 64'(bus.mem_ren), 64'(0));
    checkOutput("reset mem_wen", 64'(bus.mem_wen), 64'(0));
    checkOutput("reset mem_addr", 64'(bus.mem_addr), 64'(0));
    checkOutput("reset dataout", 64'(bus.dataout), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Cold miss, hits, byte-masked writes, write+read collision.
    for (int i = 0; i < 9; i++) begin
      doTransaction($sformatf("vec%0d", i), vecs[i].addr, vecs[i].ren, vecs[i].wen,
                    vecs[i].wdata, vecs[i].be, vecs[i].expStall, vecs[i].chkData, vecs[i].expData);
    end
    checkOutput("table refill count", 64'(rdLog.size()), 64'(4));
    for (int i = 0; i < 4 && i < rdLog.size(); i++)
      checkOutput($sformatf("table refill addr%0d", i), 64'(rdLog[i]), 64'(32'h40 + i));
    checkOutput("table writeback count", 64'(wrAddrLog.size()), 64'(0));

    // Dirty victim at index 0 evicted by a different tag.
    doTransaction("wmiss0", 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 4'hF, 8, 1'b0, 32'h0);
    base = rdLog.size();
    doTransaction("evict", 32'h1000, 1'b1, 1'b0, 32'h0, 4'h0, 16, 1'b1, 32'hC0DE0400);
    checkOutput("evict wb count", 64'(wrAddrLog.size()), 64'(4));
    for (int i = 0; i < 4 && i < wrAddrLog.size(); i++) begin
      checkOutput($sformatf("evict wb addr%0d", i), 64'(wrAddrLog[i]), 64'(i));
      checkOutput($sformatf("evict wb data%0d", i), 64'(wrDataLog[i]),
                  64'((i == 0) ? 32'hCAFEF00D : memInit(32'(i))));
    end
    checkOutput("evict refill count", 64'(rdLog.size() - base), 64'(4));
    for (int i = 0; i < 4 && base + i < rdLog.size(); i++)
      checkOutput($sformatf("evict refill addr%0d", i), 64'(rdLog[base+i]), 64'(32'h400 + i));
    doTransaction("reload0", 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 8, 1'b1, 32'hCAFEF00D);
    checkOutput("reload0 no wb", 64'(wrAddrLog.size()), 64'(4));

    // Reset after two refill acks aborts the burst and invalidates everything.
    base = rdLog.size();
    applyStimulus(32'h2000, 1'b1, 1'b0, '0, '0);
    n = 0;
    while (rdLog.size() < base + 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("abort acks seen", 64'(rdLog.size() - base), 64'(2));
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort mem_ren", 64'(bus.mem_ren), 64'(0));
    checkOutput("abort memReady", 64'(bus.memReady), 64'(1));
    applyStimulus(32'h2000, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    base = rdLog.size();
    doTransaction("reread", 32'h2000, 1'b1, 1'b0, 32'h0, 4'h0, 8, 1'b1, 32'hC0DE0800);
    checkOutput("reread count", 64'(rdLog.size() - base), 64'(4));
    for (int i = 0; i < 4 && base + i < rdLog.size(); i++)
      checkOutput($sformatf("reread addr%0d", i), 64'(rdLog[base+i]), 64'(32'h800 + i));
    doTransaction("post-reset 0x100", 32'h100, 1'b1, 1'b0, 32'h0, 4'h0, 8, 1'b1, 32'hC0DE0040);

    // Memory withholds its ack for ten cycles mid-refill.
    holdAck = 1'b1;
    applyStimulus(32'h3000, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("hold%0d memReady", i), 64'(bus.memReady), 64'(0));
      if (i >= 1) begin
        checkOutput($sformatf("hold%0d mem_addr", i), 64'(bus.mem_addr), 64'(32'hC00));
        checkOutput($sformatf("hold%0d mem_ren", i), 64'(bus.mem_ren), 64'(1));
      end
    end
    holdAck = 1'b0;
    doTransaction("hold finish", 32'h3000, 1'b1, 1'b0, 32'h0, 4'h0, 7, 1'b1, 32'hC0DE0C00);

    // Read miss at word offset 2, then a same-line request.
`ifdef IMEM_CRITICAL_FWD_EN
    doTransaction("fwd miss", 32'h4008, 1'b1, 1'b0, 32'h0, 4'h0, 5, 1'b1, 32'hC0DE1002);
    doTransaction("fwd follow", 32'h4000, 1'b1, 1'b0, 32'h0, 4'h0, 2, 1'b1, 32'hC0DE1000);
`else
    doTransaction("off2 miss", 32'h4008, 1'b1, 1'b0, 32'h0, 4'h0, 8, 1'b1, 32'hC0DE1002);
    doTransaction("off2 follow", 32'h4000, 1'b1, 1'b0, 32'h0, 4'h0, 0, 1'b1, 32'hC0DE1000);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
